// File: rtl/i2c_wiper_target.sv
// ---------------------------------------------------------------------------
// i2c_wiper_target
//
// Minimal I2C target that holds one 8-bit "wiper" register.
//   * Write transaction: every data byte loads wiper with min(byte, MAX_VALUE)
//     and pulses wr_strobe for one CLK; every byte is ACKed.
//   * Read transaction: wiper is returned repeatedly while the controller
//     ACKs; a NACK ends the read.
//   * Address mismatch: no ACK, bus ignored until the next START/STOP.
//   * No clock stretching. SDA is only driven low (open-drain).
//
// Ports
//   CLK         system clock
//   rst         synchronous active-high reset
//   scl_in      raw SCL pin level (asynchronous to CLK)
//   sda_in      raw SDA pin level (asynchronous to CLK)
//   sda_enable  1 = pull SDA low, 0 = release
//   wiper       current stored value
//   wr_strobe   one-CLK pulse when wiper is written
//   busy        high from START until STOP or address mismatch
// ---------------------------------------------------------------------------
module i2c_wiper_target #(
    parameter logic [6:0] ADDR        = 7'h2F,
    parameter logic [7:0] RESET_VALUE = 8'd64,
    parameter logic [7:0] MAX_VALUE   = 8'd127
) (
    input  logic       CLK,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_enable,
    output logic [7:0] wiper,
    output logic       wr_strobe,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_WRITE,
        S_WRITE_ACK,
        S_READ,
        S_READ_ACK,
        S_WAIT_STOP
    } state_t;

    // [0],[1] form the synchronizer; [2] is the previous synced value used
    // for edge detection.
    logic [2:0] scl_sync_q, scl_sync_d;
    logic [2:0] sda_sync_q, sda_sync_d;

    state_t     state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shreg_q, shreg_d;
    logic       rw_q, rw_d;
    logic       sda_enable_q, sda_enable_d;
    logic [7:0] wiper_q, wiper_d;
    logic       wr_strobe_q, wr_strobe_d;
    logic       busy_q, busy_d;

    logic       scl_now, scl_prev, sda_now, sda_prev;
    logic       scl_rise, scl_fall, start_det, stop_det;
    logic [7:0] byte_in;
    logic [7:0] clamped;

    assign scl_now   = scl_sync_q[1];
    assign scl_prev  = scl_sync_q[2];
    assign sda_now   = sda_sync_q[1];
    assign sda_prev  = sda_sync_q[2];

    assign scl_rise  = scl_now & ~scl_prev;
    assign scl_fall  = ~scl_now & scl_prev;
    assign start_det = scl_now & sda_prev & ~sda_now;
    assign stop_det  = scl_now & ~sda_prev & sda_now;

    // Byte as it will look once the bit currently on SDA is shifted in.
    assign byte_in   = {shreg_q[6:0], sda_now};
    assign clamped   = (byte_in > MAX_VALUE) ? MAX_VALUE : byte_in;

    always_comb begin
        // NOTE: every signal assigned below gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        scl_sync_d   = {scl_sync_q[1:0], scl_in};
        sda_sync_d   = {sda_sync_q[1:0], sda_in};
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        rw_d         = rw_q;
        sda_enable_d = sda_enable_q;
        wiper_d      = wiper_q;
        wr_strobe_d  = 1'b0;
        busy_d       = busy_q;

        // Bus conditions win over any bit handling in the same cycle.
        if (start_det) begin
            state_d      = S_ADDR;
            bit_cnt_d    = 4'd0;
            sda_enable_d = 1'b0;
            busy_d       = 1'b1;
        end else if (stop_det) begin
            state_d      = S_IDLE;
            sda_enable_d = 1'b0;
            busy_d       = 1'b0;
        end else begin
            unique case (state_q)
                S_ADDR: begin
                    if (scl_rise) begin
                        shreg_d   = byte_in;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d = 4'd0;
                            if (byte_in[7:1] == ADDR) begin
                                rw_d    = byte_in[0];
                                state_d = S_ADDR_ACK;
                            end else begin
                                state_d = S_WAIT_STOP;
                                busy_d  = 1'b0;
                            end
                        end
                    end
                end

                // First SCL fall (end of bit 8) pulls SDA for the ACK, the
                // second (end of bit 9) releases it. A read starts driving
                // bit 7 of the latched wiper on that same second fall.
                S_ADDR_ACK, S_WRITE_ACK: begin
                    if (scl_fall) begin
                        if (!sda_enable_q) begin
                            sda_enable_d = 1'b1;
                        end else begin
                            sda_enable_d = 1'b0;
                            bit_cnt_d    = 4'd0;
                            if (state_q == S_ADDR_ACK && rw_q) begin
                                state_d      = S_READ;
                                shreg_d      = wiper_q;
                                sda_enable_d = ~wiper_q[7];
                            end else begin
                                state_d = S_WRITE;
                            end
                        end
                    end
                end

                S_WRITE: begin
                    if (scl_rise) begin
                        shreg_d   = byte_in;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d   = 4'd0;
                            wiper_d     = clamped;
                            wr_strobe_d = 1'b1;
                            state_d     = S_WRITE_ACK;
                        end
                    end
                end

                // bit_cnt counts SCL rises; the fall after the 8th rise
                // hands SDA back to the controller for its ACK/NACK.
                S_READ: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_enable_d = 1'b0;
                            bit_cnt_d    = 4'd0;
                            state_d      = S_READ_ACK;
                        end else begin
                            shreg_d      = {shreg_q[6:0], 1'b0};
                            sda_enable_d = ~shreg_q[6];
                        end
                    end
                end

                // bit_cnt == 9 marks "controller ACKed, reload on next fall".
                S_READ_ACK: begin
                    if (scl_rise) begin
                        if (sda_now) begin
                            state_d = S_WAIT_STOP;
                        end else begin
                            bit_cnt_d = 4'd9;
                        end
                    end else if (scl_fall && bit_cnt_q == 4'd9) begin
                        state_d      = S_READ;
                        bit_cnt_d    = 4'd0;
                        shreg_d      = wiper_q;
                        sda_enable_d = ~wiper_q[7];
                    end
                end

                default: ; // S_IDLE, S_WAIT_STOP: wait for START/STOP
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples the pre-edge value of the others.
        if (rst) begin
            scl_sync_q   <= 3'b111;
            sda_sync_q   <= 3'b111;
            state_q      <= S_IDLE;
            bit_cnt_q    <= 4'd0;
            shreg_q      <= 8'd0;
            rw_q         <= 1'b0;
            sda_enable_q <= 1'b0;
            wiper_q      <= RESET_VALUE;
            wr_strobe_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            scl_sync_q   <= scl_sync_d;
            sda_sync_q   <= sda_sync_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            rw_q         <= rw_d;
            sda_enable_q <= sda_enable_d;
            wiper_q      <= wiper_d;
            wr_strobe_q  <= wr_strobe_d;
            busy_q       <= busy_d;
        end
    end

    assign sda_enable = sda_enable_q;
    assign wiper      = wiper_q;
    assign wr_strobe  = wr_strobe_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_i2c_wiper_target.sv
// ---------------------------------------------------------------------------
// tb_i2c_wiper_target
//
// Bit-banged I2C controller drives the target over a wired-AND SDA line.
// A reference model keeps the expected wiper value; each expected write is
// queued and a monitor pops it whenever the target pulses wr_strobe.
// Directed transactions cover the documented scenarios, then a randomized
// mix of writes (matching and non-matching address) and reads follows.
// ---------------------------------------------------------------------------
module tb_i2c_wiper_target;

    localparam logic [6:0] ADDR    = 7'h2F;
    localparam logic [7:0] RST_VAL = 8'h40;
    localparam logic [7:0] MAX_VAL = 8'h7F;
    localparam int         Q       = 8;    // CLKs per quarter SCL period

    logic       CLK = 1'b0;
    logic       rst = 1'b1;
    logic       scl = 1'b1;
    logic       sda_ctrl = 1'b1;
    logic       sda_bus;
    logic       sda_enable;
    logic [7:0] wiper;
    logic       wr_strobe;
    logic       busy;

    assign sda_bus = sda_ctrl & ~sda_enable;

    i2c_wiper_target #(
        .ADDR       (ADDR),
        .RESET_VALUE(RST_VAL),
        .MAX_VALUE  (MAX_VAL)
    ) dut (
        .CLK       (CLK),
        .rst       (rst),
        .scl_in    (scl),
        .sda_in    (sda_bus),
        .sda_enable(sda_enable),
        .wiper     (wiper),
        .wr_strobe (wr_strobe),
        .busy      (busy)
    );

    always #5 CLK = ~CLK;

    int         total = 0;
    int         bad = 0;
    int         strobe_cnt = 0;
    int         sda_low_cnt = 0;
    logic [7:0] model_wiper = RST_VAL;
    logic [7:0] exp_wr_q[$];
    logic [7:0] tx_bytes[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] clamp(input logic [7:0] b);
        return (b > MAX_VAL) ? MAX_VAL : b;
    endfunction

    // Scoreboard monitor: pops an expected wiper value on every strobe.
    initial begin
        logic prev_strobe;
        prev_strobe = 1'b0;
        forever begin
            @(negedge CLK);
            if (sda_enable) sda_low_cnt++;
            if (wr_strobe) begin
                strobe_cnt++;
                check("strobe_one_cycle", {31'd0, prev_strobe}, 32'd0);
                if (exp_wr_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_strobe: got wiper %0h with nothing queued", wiper);
                end else begin
                    check("strobe_wiper", {24'd0, wiper}, {24'd0, exp_wr_q.pop_front()});
                end
            end
            prev_strobe = wr_strobe;
        end
    end

    // ---------------- bus primitives ----------------
    task automatic wait_q();
        repeat (Q) @(negedge CLK);
    endtask

    task automatic i2c_start();
        sda_ctrl = 1'b1; wait_q();
        scl = 1'b1;      wait_q();
        sda_ctrl = 1'b0; wait_q();
        scl = 1'b0;      wait_q();
    endtask

    task automatic i2c_stop();
        sda_ctrl = 1'b0; wait_q();
        scl = 1'b1;      wait_q();
        sda_ctrl = 1'b1; wait_q();
    endtask

    task automatic send_bit(input logic b);
        sda_ctrl = b; wait_q();
        scl = 1'b1;   wait_q();
        wait_q();
        scl = 1'b0;   wait_q();
    endtask

    task automatic recv_bit(output logic b);
        sda_ctrl = 1'b1; wait_q();
        scl = 1'b1;      wait_q();
        b = sda_bus;     wait_q();
        scl = 1'b0;      wait_q();
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic recv_byte(output logic [7:0] b);
        logic x;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(x);
            b[i] = x;
        end
    endtask

    // ---------------- transactions ----------------
    // Writes every byte in tx_bytes to address a.
    task automatic write_txn(input logic [6:0] a);
        logic ack;
        logic match;
        int   strobes_before;
        match = (a == ADDR);
        strobes_before = strobe_cnt;
        sda_low_cnt = 0;
        i2c_start();
        check("busy_after_start", {31'd0, busy}, 32'd1);
        send_byte({a, 1'b0});
        recv_bit(ack);
        check("addr_ack", {31'd0, ack}, match ? 32'd0 : 32'd1);
        if (!match) check("busy_after_mismatch", {31'd0, busy}, 32'd0);
        foreach (tx_bytes[i]) begin
            if (match) begin
                model_wiper = clamp(tx_bytes[i]);
                exp_wr_q.push_back(model_wiper);
            end
            send_byte(tx_bytes[i]);
            recv_bit(ack);
            check("data_ack", {31'd0, ack}, match ? 32'd0 : 32'd1);
        end
        i2c_stop();
        wait_q();
        check("busy_after_stop", {31'd0, busy}, 32'd0);
        check("wiper_after_write", {24'd0, wiper}, {24'd0, model_wiper});
        check("strobe_count", strobe_cnt - strobes_before, match ? tx_bytes.size() : 0);
        if (!match) check("sda_never_low", sda_low_cnt, 32'd0);
    endtask

    // Reads n bytes, ACKing all but the last.
    task automatic read_txn(input int n);
        logic       ack;
        logic [7:0] b;
        i2c_start();
        send_byte({ADDR, 1'b1});
        recv_bit(ack);
        check("read_addr_ack", {31'd0, ack}, 32'd0);
        for (int i = 0; i < n; i++) begin
            recv_byte(b);
            check("read_byte", {24'd0, b}, {24'd0, model_wiper});
            send_bit(i == n - 1);
        end
        check("sda_released_after_nack", {31'd0, sda_enable}, 32'd0);
        i2c_stop();
        wait_q();
        check("busy_after_read", {31'd0, busy}, 32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic ack;
        int   strobes_before;

        repeat (5) @(negedge CLK);
        check("rst_wiper", {24'd0, wiper}, {24'd0, RST_VAL});
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_sda_enable", {31'd0, sda_enable}, 32'd0);
        check("rst_wr_strobe", {31'd0, wr_strobe}, 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge CLK);

        // Plain write, clamped write, wrong address.
        tx_bytes = '{8'h46}; write_txn(ADDR);
        tx_bytes = '{8'hC8}; write_txn(ADDR);
        tx_bytes = '{8'h10}; write_txn(7'h2E);

        // Read back twice (ACK then NACK).
        tx_bytes = '{8'h46}; write_txn(ADDR);
        read_txn(2);

        // Aborted byte, repeated START, then a full write.
        strobes_before = strobe_cnt;
        i2c_start();
        send_byte({ADDR, 1'b0});
        recv_bit(ack);
        check("abort_addr_ack", {31'd0, ack}, 32'd0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        i2c_start();
        send_byte({ADDR, 1'b0});
        recv_bit(ack);
        check("rstart_addr_ack", {31'd0, ack}, 32'd0);
        model_wiper = 8'h05;
        exp_wr_q.push_back(model_wiper);
        send_byte(8'h05);
        recv_bit(ack);
        check("rstart_data_ack", {31'd0, ack}, 32'd0);
        i2c_stop();
        wait_q();
        check("rstart_wiper", {24'd0, wiper}, 32'h05);
        check("rstart_strobes", strobe_cnt - strobes_before, 32'd1);

        // Reset while the address ACK is being driven.
        i2c_start();
        send_byte({ADDR, 1'b0});
        sda_ctrl = 1'b1;
        wait_q();
        check("ack_driven_before_rst", {31'd0, sda_enable}, 32'd1);
        rst = 1'b1;
        @(negedge CLK);
        check("rst_mid_sda_release", {31'd0, sda_enable}, 32'd0);
        check("rst_mid_wiper", {24'd0, wiper}, {24'd0, RST_VAL});
        rst = 1'b0;
        model_wiper = RST_VAL;
        scl = 1'b0;
        i2c_stop();
        wait_q();
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_wiper_after_stop", {24'd0, wiper}, {24'd0, RST_VAL});

        // Randomized mix.
        for (int t = 0; t < 12; t++) begin
            int kind;
            int n;
            kind = $urandom_range(0, 2);
            n    = $urandom_range(1, 3);
            if (kind == 2) begin
                read_txn(n);
            end else begin
                logic [6:0] a;
                a = ADDR;
                if ($urandom_range(0, 4) == 0) a = ADDR ^ (7'd1 << $urandom_range(0, 6));
                tx_bytes.delete();
                for (int i = 0; i < n; i++) tx_bytes.push_back(8'($urandom_range(0, 255)));
                write_txn(a);
            end
        end

        repeat (4) @(negedge CLK);
        check("scoreboard_drained", exp_wr_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2c_wiper_target.md
I2C_WIPER_TARGET -- requirements
Module: i2c_wiper_target

Interface
REQ-001 The block SHALL have one clock, CLK; reset is synchronous and active-high, port rst.
REQ-002 Parameter ADDR, default 7'h2F: 7-bit target address the block answers to.
REQ-003 Parameter RESET_VALUE, default 8'd64: value wiper takes at reset.
REQ-004 Parameter MAX_VALUE, default 8'd127: upper clamp for written values.
REQ-005 Port CLK  input  1  system clock, 16 MHz.
REQ-006 Port rst  input  1  synchronous active-high reset.
REQ-007 Port scl_in  input  1  raw SCL pin level, asynchronous to CLK.
REQ-008 Port sda_in  input  1  raw SDA pin level, asynchronous to CLK.
REQ-009 Port sda_enable  output  1  1 = pull SDA low (open-drain); 0 = release.
REQ-010 Port wiper  output  8  current stored value.
REQ-011 Port wr_strobe  output  1  one-CLK pulse when wiper is written.
REQ-012 Port busy  output  1  high from START until STOP or address mismatch.

Function
REQ-013 scl_in and sda_in SHALL each pass a 2-flop synchronizer; edges SHALL be detected against a third registered copy, so a pin edge acts 3 CLK later.
REQ-014 START = synced SDA falling while synced SCL high; STOP = synced SDA rising while synced SCL high.
REQ-015 States: IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, WAIT_STOP.
REQ-016 START in any state (including repeated START) SHALL go to ADDR, clear the bit counter, release sda_enable, set busy.
REQ-017 STOP in any state SHALL go to IDLE, release sda_enable, clear busy.
REQ-018 START/STOP detection SHALL take priority over bit handling in the same CLK.
REQ-019 Bits SHALL be sampled on SCL rising edge, MSB first; sda_enable SHALL change only on the CLK after an SCL falling edge.
REQ-020 ADDR: after 8 bits, address match SHALL go to ADDR_ACK (R/W=0 -> WRITE, 1 -> READ); mismatch SHALL go to WAIT_STOP, no ACK, busy cleared.
REQ-021 ACK: sda_enable asserted on the SCL falling edge ending bit 8, released on the SCL falling edge ending bit 9.
REQ-022 WRITE: on the SCL rising edge sampling the 8th data bit, wiper SHALL load min(byte, MAX_VALUE) and wr_strobe pulse for exactly 1 CLK; then WRITE_ACK, always ACK.
REQ-023 Multiple data bytes in one write transaction SHALL each update wiper and pulse wr_strobe; last byte wins.
REQ-024 READ: the byte source is wiper, latched at the SCL falling edge ending the ACK; bit 7 is driven on that edge, later bits on subsequent falling edges; sda_enable = ~bit.
REQ-025 READ_ACK: SDA released; controller ACK (0) on 9th rising edge SHALL reload and send another byte; NACK (1) SHALL go to WAIT_STOP.
REQ-026 WAIT_STOP SHALL ignore all bits until START or STOP.
REQ-027 No clock stretching; sda_enable SHALL never change while synced SCL is high, except release on START/STOP/rst.
REQ-028 A transaction aborted by START/STOP mid-byte SHALL not modify wiper.

Reset
REQ-029 rst SHALL set state IDLE, sda_enable 0, wiper RESET_VALUE, wr_strobe 0, busy 0, bit counter 0, synchronizer flops 1.
REQ-030 rst mid-transaction SHALL release SDA on the next CLK; the block SHALL then ignore the bus until a new START.

Verification
REQ-031 Write 0x2F/W, data 0x46 -> ACK after address and data, wiper = 0x46, one wr_strobe pulse, busy falls at STOP.
REQ-032 Write 0x2F/W, data 0xC8 -> ACK, wiper = 0x7F (clamped).
REQ-033 Write 0x2E/W, data 0x10 -> SDA never pulled low, wiper unchanged, no wr_strobe.
REQ-034 After wiper = 0x46, read 0x2F/R, controller ACK then NACK -> bytes 0x46, 0x46 returned; SDA released after NACK.
REQ-035 Write 0x2F/W, 4 data bits, repeated START, write 0x2F/W 0x05 -> wiper = 0x05, exactly one wr_strobe.
REQ-036 rst asserted during ADDR_ACK low phase -> sda_enable 0 on next CLK, wiper = 0x40.
